timer_unit_presc_ctrl: RTL

Sequencing controller for one timer channel built around a 32-bit prescaler counter. Drives the prescaler's reset/enable/compare/write controls and consumes its one-cycle `target_reached` pulse as the timer tick. Counts ticks against a programmable compare value and raises a one-cycle event. Supports start, stop and reset commands, and accepts configuration through a valid/ready port with shadow update at event boundaries. Sits between the timer register file and the prescaler counter instance.

---
 rtl/timer_unit_presc_ctrl.sv | 92 +++++++++
 1 files changed

// File: rtl/timer_unit_presc_ctrl.sv
// timer_unit_presc_ctrl: timer channel sequencer driving a prescaler and counting its ticks against a compare value
module timer_unit_presc_ctrl #(
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic               cfg_presc_en_i,
  input  logic [PRESC_W-1:0] cfg_presc_i,
  input  logic               cfg_oneshot_i,
  input  logic [CNT_W-1:0]   cfg_cmp_i,
  input  logic               cmd_start_i,
  input  logic               cmd_stop_i,
  input  logic               cmd_reset_i,
  output logic               presc_reset_o,
  output logic               presc_enable_o,
  output logic               presc_write_o,
  output logic [31:0]        presc_value_o,
  output logic [31:0]        presc_compare_o,
  input  logic               presc_target_i,
  output logic               tick_o,
  output logic               event_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               busy_o
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, PAUSE} state_e;
  state_e state_q, state_d;
  logic en_q, en_d, os_q, os_d, pend_q, pend_d;
  logic sh_en_q, sh_os_q;
  logic [PRESC_W-1:0] p_q, p_d, sh_p_q;
  logic [CNT_W-1:0] c_q, c_d, sh_c_q, count_q, count_d;
  logic event_q, event_d, busy_q, busy_d, prst_q, prst_d, pen_q, pen_d;
  logic running, accept, direct, match, apply;
  assign running = state_q == RUN;
  assign accept  = cfg_valid_i & ~pend_q;
  assign direct  = accept & (state_q == IDLE || state_q == PAUSE);
  assign tick_o  = running & (en_q ? presc_target_i : 1'b1);
  assign match   = tick_o & (count_q == c_q);
  // shadow config lands the cycle after an event, or immediately on a reset command
  assign apply   = pend_q & (event_q | cmd_reset_i);
  assign cfg_ready_o     = ~pend_q;
  assign presc_compare_o = {{(32-PRESC_W){1'b0}}, p_q};
  assign presc_value_o   = '0;
  assign presc_write_o   = 1'b0;
  assign presc_reset_o   = prst_q;
  assign presc_enable_o  = pen_q;
  assign event_o         = event_q;
  assign count_o         = count_q;
  assign busy_o          = busy_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (cmd_reset_i) state_d = running ? LOAD : (state_q == LOAD ? RUN : state_q);
    else if (state_q == LOAD) state_d = RUN;
    else if (running & cmd_stop_i) state_d = PAUSE;
    else if (cmd_start_i & state_q == IDLE) state_d = LOAD;
    else if (cmd_start_i & state_q == PAUSE) state_d = RUN;
    else if (match & os_q) state_d = IDLE;
  end
  always_comb begin
    en_d    = apply ? sh_en_q : direct ? cfg_presc_en_i : en_q;
    p_d     = apply ? sh_p_q  : direct ? cfg_presc_i    : p_q;
    os_d    = apply ? sh_os_q : direct ? cfg_oneshot_i  : os_q;
    c_d     = apply ? sh_c_q  : direct ? cfg_cmp_i      : c_q;
    pend_d  = apply ? 1'b0 : (accept & ~direct) ? 1'b1 : pend_q;
    count_d = cmd_reset_i ? '0 : tick_o ? (match ? '0 : count_q + 1'b1) : count_q;
    event_d = match & ~cmd_reset_i;
    busy_d  = state_d == LOAD || state_d == RUN;
    pen_d   = state_d == RUN && en_d;
    prst_d  = state_d == LOAD || (apply && running && sh_p_q != p_q);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      {en_q, os_q, pend_q, sh_en_q, sh_os_q} <= '0;
      {p_q, sh_p_q, c_q, sh_c_q, count_q} <= '0;
      {event_q, busy_q, prst_q, pen_q} <= '0;
    end else begin
      {en_q, os_q, pend_q} <= {en_d, os_d, pend_d};
      {p_q, c_q, count_q} <= {p_d, c_d, count_d};
      {event_q, busy_q, prst_q, pen_q} <= {event_d, busy_d, prst_d, pen_d};
      if (accept & ~direct) begin
        {sh_en_q, sh_os_q} <= {cfg_presc_en_i, cfg_oneshot_i};
        {sh_p_q, sh_c_q} <= {cfg_presc_i, cfg_cmp_i};
      end
    end
  end
endmodule
